// File: rtl/pcm2706_serial_tx.sv
// pcm2706_serial_tx
// Transmitter end of the PCM2706 serial audio link. It turns parallel stereo
// samples into BCK / LRCK / DATA, the same wires that pcm2706_interface
// receives. A one-deep stereo holding register with a valid/ready handshake
// decouples the sample source from frame timing.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active high
//   left_in     in   [DATA_W] left sample, two's complement
//   right_in    in   [DATA_W] right sample, two's complement
//   load        in   sample pair valid
//   ready       out  holding register empty (load accepted on load & ready)
//   serial_clk  out  BCK, period 2*BCK_DIV clk
//   lr_clk      out  LRCK, 0 = left slots, 1 = right slots
//   serial_out  out  serial data, MSB first, changes on BCK falling edge
//   frame_start out  1-clk pulse when a frame moves into the shift register
//   underrun    out  1-clk pulse with frame_start when the holding reg was empty
module pcm2706_serial_tx #(
    parameter int DATA_W    = 16,
    parameter int BCK_DIV   = 8,
    parameter int I2S_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic              load,
    output logic              ready,
    output logic              serial_clk,
    output logic              lr_clk,
    output logic              serial_out,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FRAME_W = 2 * DATA_W;
    localparam int SLOT_W  = $clog2(FRAME_W);
    localparam int DIV_W   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

    logic [DIV_W-1:0]   div_q,   div_d;
    logic               bck_q,   bck_d;
    logic [SLOT_W-1:0]  slot_q,  slot_d;
    logic               lr_q,    lr_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] hold_q,  hold_d;
    logic               full_q,  full_d;
    logic               first_q, first_d;
    logic               fs_q,    fs_d;
    logic               ur_q,    ur_d;

    logic              div_tc;
    logic              bck_fall;
    logic [SLOT_W-1:0] slot_nx;
    logic              reload;
    logic              accept;

    always_comb begin
        div_tc   = (div_q == DIV_W'(BCK_DIV - 1));
        // BCK is currently high and about to toggle: this edge is the fall
        bck_fall = div_tc & bck_q;
        slot_nx  = (slot_q == SLOT_W'(FRAME_W - 1)) ? '0 : slot_q + SLOT_W'(1);
        reload   = bck_fall && (slot_nx == SLOT_W'(I2S_DELAY));
        accept   = load & ~full_q;

        div_d   = div_tc ? '0 : div_q + DIV_W'(1);
        bck_d   = div_tc ? ~bck_q : bck_q;
        slot_d  = slot_q;
        lr_d    = lr_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        full_d  = full_q;
        first_d = first_q;
        // The reload sees the holding register as it was before this edge,
        // so a load accepted in the reload cycle waits for the next frame.
        fs_d    = reload;
        ur_d    = reload & ~full_q & ~first_q;

        if (bck_fall) begin
            slot_d = slot_nx;
            lr_d   = (slot_nx >= SLOT_W'(DATA_W));
            if (reload) begin
                shift_d = full_q ? hold_q : '0;
                first_d = 1'b0;
            end else begin
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
        end

        if (accept) begin
            hold_d = {left_in, right_in};
            full_d = 1'b1;
        end else if (reload) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            bck_q   <= 1'b0;
            slot_q  <= '0;
            lr_q    <= 1'b0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            first_q <= 1'b1;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            bck_q   <= bck_d;
            slot_q  <= slot_d;
            lr_q    <= lr_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            first_q <= first_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
        end
    end

    assign ready       = ~full_q;
    assign serial_clk  = bck_q;
    assign lr_clk      = lr_q;
    assign serial_out  = shift_q[FRAME_W-1];
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_pcm2706_serial_tx.sv
module tb_pcm2706_serial_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] left_in = '0, right_in = '0;
    logic        load = 1'b0;
    logic        ready, serial_clk, lr_clk, serial_out, frame_start, underrun;

    logic [15:0] left0 = '0, right0 = '0;
    logic        load0 = 1'b0;
    logic        ready0, bck0, lr0, so0, fs0, ur0;

    int n_cmp = 0;
    int n_err = 0;
    int n = 0;   // clk edges since reset release

    always #5 clk = ~clk;

    pcm2706_serial_tx #(.DATA_W(16), .BCK_DIV(2), .I2S_DELAY(1)) dut (
        .clk(clk), .rst(rst), .left_in(left_in), .right_in(right_in),
        .load(load), .ready(ready), .serial_clk(serial_clk), .lr_clk(lr_clk),
        .serial_out(serial_out), .frame_start(frame_start), .underrun(underrun)
    );

    pcm2706_serial_tx #(.DATA_W(16), .BCK_DIV(2), .I2S_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .left_in(left0), .right_in(right0),
        .load(load0), .ready(ready0), .serial_clk(bck0), .lr_clk(lr0),
        .serial_out(so0), .frame_start(fs0), .underrun(ur0)
    );

    typedef struct {
        int   n;
        logic bck, lr, fs, ur, rdy, so, fs0, so0;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic go_to(input int target);
        while (n < target) step();
    endtask

    initial begin
        logic [31:0] word;
        int s;

        tbl[0]  = '{1,   0,0,0,0,1,0, 0,0};
        tbl[1]  = '{2,   1,0,0,0,1,0, 0,0};
        tbl[2]  = '{4,   0,0,1,0,1,0, 0,0};
        tbl[3]  = '{5,   0,0,0,0,1,0, 0,0};
        tbl[4]  = '{63,  1,0,0,0,1,0, 0,0};
        tbl[5]  = '{64,  0,1,0,0,1,0, 0,0};
        tbl[6]  = '{127, 1,1,0,0,1,0, 0,0};
        tbl[7]  = '{128, 0,0,0,0,1,0, 1,1};
        tbl[8]  = '{129, 0,0,0,0,1,0, 0,1};
        tbl[9]  = '{132, 0,0,1,1,1,0, 0,0};
        tbl[10] = '{133, 0,0,0,0,1,0, 0,0};
        tbl[11] = '{188, 0,0,0,0,1,0, 0,1};
        tbl[12] = '{191, 1,0,0,0,1,0, 0,1};
        tbl[13] = '{192, 0,1,0,0,1,0, 0,0};

        // Held in reset: every output at its reset value
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bck", {31'd0, serial_clk}, 32'd0);
        chk("rst_lr", {31'd0, lr_clk}, 32'd0);
        chk("rst_so", {31'd0, serial_out}, 32'd0);
        chk("rst_rdy", {31'd0, ready}, 32'd1);
        chk("rst_fs", {31'd0, frame_start}, 32'd0);
        chk("rst_ur", {31'd0, underrun}, 32'd0);
        chk("rst_bck0", {31'd0, bck0}, 32'd0);

        // Left-justified instance gets its pair on the first edge
        left0  = 16'h8001;
        right0 = 16'h0000;
        load0  = 1'b1;
        rst    = 1'b0;
        n      = 0;
        step();
        load0 = 1'b0;

        // Frame timing, empty frames, and the left-justified frame
        for (int i = 0; i < 14; i++) begin
            go_to(tbl[i].n);
            chk("t_bck", {31'd0, serial_clk}, {31'd0, tbl[i].bck});
            chk("t_lr",  {31'd0, lr_clk},     {31'd0, tbl[i].lr});
            chk("t_fs",  {31'd0, frame_start},{31'd0, tbl[i].fs});
            chk("t_ur",  {31'd0, underrun},   {31'd0, tbl[i].ur});
            chk("t_rdy", {31'd0, ready},      {31'd0, tbl[i].rdy});
            chk("t_so",  {31'd0, serial_out}, {31'd0, tbl[i].so});
            chk("t_fs0", {31'd0, fs0},        {31'd0, tbl[i].fs0});
            chk("t_so0", {31'd0, so0},        {31'd0, tbl[i].so0});
        end

        // Accepted load, then an ignored load while full
        left_in  = 16'hA5C3;
        right_in = 16'h0F01;
        load     = 1'b1;
        step();
        load = 1'b0;
        chk("ld_rdy", {31'd0, ready}, 32'd0);
        go_to(200);
        left_in  = 16'h1234;
        right_in = 16'h5678;
        load     = 1'b1;
        step();
        load = 1'b0;
        chk("ign_rdy", {31'd0, ready}, 32'd0);

        go_to(260);
        chk("f2_fs", {31'd0, frame_start}, 32'd1);
        chk("f2_ur", {31'd0, underrun}, 32'd0);
        chk("f2_rdy", {31'd0, ready}, 32'd1);
        word = 32'hA5C30F01;
        for (s = 1; s <= 32; s++) begin
            go_to(256 + 4 * s + 1);
            chk("f2_so", {31'd0, serial_out}, {31'd0, word[32 - s]});
            chk("f2_lr", {31'd0, lr_clk}, {31'd0, ((s % 32) >= 16)});
        end

        // Nothing loaded: zero frame with underrun
        go_to(388);
        chk("u_fs", {31'd0, frame_start}, 32'd1);
        chk("u_ur", {31'd0, underrun}, 32'd1);
        step();
        chk("u_ur_pulse", {31'd0, underrun}, 32'd0);
        chk("u_fs_pulse", {31'd0, frame_start}, 32'd0);
        for (s = 1; s < 32; s += 5) begin
            go_to(384 + 4 * s + 1);
            chk("u_so", {31'd0, serial_out}, 32'd0);
        end

        // Load landing exactly on the reload edge
        go_to(515);
        left_in  = 16'hC001;
        right_in = 16'h8003;
        load     = 1'b1;
        step();
        load = 1'b0;
        chk("rl_fs", {31'd0, frame_start}, 32'd1);
        chk("rl_ur", {31'd0, underrun}, 32'd1);
        chk("rl_rdy", {31'd0, ready}, 32'd0);
        chk("rl_so", {31'd0, serial_out}, 32'd0);
        go_to(644);
        chk("rl2_fs", {31'd0, frame_start}, 32'd1);
        chk("rl2_ur", {31'd0, underrun}, 32'd0);
        chk("rl2_so1", {31'd0, serial_out}, 32'd1);
        go_to(649);
        chk("rl2_so2", {31'd0, serial_out}, 32'd1);
        go_to(653);
        chk("rl2_so3", {31'd0, serial_out}, 32'd0);

        // Fill holding, then reset in slot 9
        go_to(660);
        left_in  = 16'hFFFF;
        right_in = 16'hFFFF;
        load     = 1'b1;
        step();
        load = 1'b0;
        go_to(678);
        chk("pre_bck", {31'd0, serial_clk}, 32'd1);
        chk("pre_rdy", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_bck", {31'd0, serial_clk}, 32'd0);
        chk("mid_rdy", {31'd0, ready}, 32'd1);
        chk("mid_lr", {31'd0, lr_clk}, 32'd0);
        chk("mid_so", {31'd0, serial_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
        go_to(4);
        chk("rs_fs", {31'd0, frame_start}, 32'd1);
        chk("rs_ur", {31'd0, underrun}, 32'd0);
        chk("rs_rdy", {31'd0, ready}, 32'd1);
        go_to(5);
        chk("rs_so", {31'd0, serial_out}, 32'd0);
        go_to(9);
        chk("rs_so2", {31'd0, serial_out}, 32'd0);
        go_to(132);
        chk("rs2_fs", {31'd0, frame_start}, 32'd1);
        chk("rs2_ur", {31'd0, underrun}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
